// File: rtl/mdclcg_pkg.sv
// mdclcg_pkg: shared constants for the MDCLCG output demultiplexer
// Holds the word width, the lane select encodings and the default lane FIFO depth.
package mdclcg_pkg;
  localparam int WORD_W = 64;
  localparam int DEFAULT_DEPTH = 2;
  localparam logic LANE0 = 1'b0;
  localparam logic LANE1 = 1'b1;
endpackage

// File: rtl/lane_fifo.sv
// lane_fifo: synchronous FIFO with a registered head word
// Ports: clk, rst (sync, active-high), push/din write side, pop read side,
// full/empty flags, cnt occupancy, head registered head word (holds when empty).
module lane_fifo
  import mdclcg_pkg::*;
#(
  parameter int WIDTH = WORD_W,
  parameter int DEPTH = DEFAULT_DEPTH,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    cnt,
  output logic [WIDTH-1:0] head
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic do_push, do_pop;
  assign full = cnt_q == CW'(DEPTH);
  assign empty = cnt_q == '0;
  assign cnt = cnt_q;
  assign head = head_q;
  // head_d reads mem_d so a word pushed into an emptying FIFO is already the next head
  always_comb begin
    do_push = push && !full;
    do_pop = pop && !empty;
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    mem_d = mem_q;
    if (do_push) mem_d[wr_ptr_q] = din;
    head_d = cnt_d == '0 ? head_q : mem_d[rd_ptr_d];
  end
  always_ff @(posedge clk) mem_q <= mem_d;
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q <= '0;
      head_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q <= cnt_d;
      head_q <= head_d;
    end
  end
endmodule

// File: rtl/demux_1x2_64line_buf.sv
// demux_1x2_64line_buf: registered 1-to-2 word demultiplexer with per-lane FIFOs
// Ports: clk, rst (sync, active-high); in/in_valid/in_ready input handshake with
// lane select s; out0/out1 head words with outK_valid/outK_ready handshakes and
// outK_cnt occupancy. Define DEMUX_ALT_SEL_EN to ignore s and alternate lanes.
module demux_1x2_64line_buf
  import mdclcg_pkg::*;
#(
  parameter int WIDTH = WORD_W,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         in,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     s,
  output logic [WIDTH-1:0]         out0,
  output logic                     out0_valid,
  input  logic                     out0_ready,
  output logic [$clog2(DEPTH):0]   out0_cnt,
  output logic [WIDTH-1:0]         out1,
  output logic                     out1_valid,
  input  logic                     out1_ready,
  output logic [$clog2(DEPTH):0]   out1_cnt
);
  logic sel, accept, full0, full1, empty0, empty1;
`ifdef DEMUX_ALT_SEL_EN
  logic tog_q, tog_d;
  always_comb tog_d = accept ? ~tog_q : tog_q;
  always_ff @(posedge clk) tog_q <= rst ? 1'b0 : tog_d;
  assign sel = tog_q;
`else
  assign sel = s;
`endif
  // full flags are registered, so in_ready never looks at the consumers
  assign in_ready = sel == LANE1 ? !full1 : !full0;
  assign accept = in_valid && in_ready;
  assign out0_valid = !empty0;
  assign out1_valid = !empty1;
  lane_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_lane0 (
    .clk(clk), .rst(rst), .push(accept && sel == LANE0), .din(in), .pop(out0_ready),
    .full(full0), .empty(empty0), .cnt(out0_cnt), .head(out0)
  );
  lane_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_lane1 (
    .clk(clk), .rst(rst), .push(accept && sel == LANE1), .din(in), .pop(out1_ready),
    .full(full1), .empty(empty1), .cnt(out1_cnt), .head(out1)
  );
endmodule

// File: tb/tb_demux_1x2_64line_buf.sv
// tb_demux_1x2_64line_buf: directed self-checking bench for demux_1x2_64line_buf
module tb_demux_1x2_64line_buf;
  logic clk = 1'b0, rst = 1'b0, in_valid = 1'b0, s = 1'b0, out0_ready = 1'b0, out1_ready = 1'b0;
  logic [63:0] in = '0;
  logic in_ready, out0_valid, out1_valid;
  logic [63:0] out0, out1;
  logic [1:0] out0_cnt, out1_cnt;
  int chk_cnt = 0, pass_cnt = 0;
  demux_1x2_64line_buf dut (
    .clk(clk), .rst(rst), .in(in), .in_valid(in_valid), .in_ready(in_ready), .s(s),
    .out0(out0), .out0_valid(out0_valid), .out0_ready(out0_ready), .out0_cnt(out0_cnt),
    .out1(out1), .out1_valid(out1_valid), .out1_ready(out1_ready), .out1_cnt(out1_cnt)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    in_valid = 0; out0_ready = 0; out1_ready = 0; s = 0; in = '0; rst = 1;
    step(); step();
    rst = 0;
  endtask
  task automatic test_reset();
    do_reset();
    chk_cnt++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready got %b exp 1", in_ready); else pass_cnt++;
    chk_cnt++; if ({out0_valid, out1_valid} !== 2'b00) $display("FAIL rst_valids got %b exp 00", {out0_valid, out1_valid}); else pass_cnt++;
    chk_cnt++; if ({out0_cnt, out1_cnt} !== 4'h0) $display("FAIL rst_cnts got %h exp 0", {out0_cnt, out1_cnt}); else pass_cnt++;
    chk_cnt++; if ({out0, out1} !== 128'h0) $display("FAIL rst_outs got %h/%h exp 0/0", out0, out1); else pass_cnt++;
  endtask
  task automatic test_two_lanes();
    do_reset();
    in = 64'hA5A5_0000_0000_0001; s = 0; in_valid = 1;
    step();
    in = 64'h2; s = 1;
    step();
    in_valid = 0;
    chk_cnt++; if (out0 !== 64'hA5A5_0000_0000_0001 || !out0_valid) $display("FAIL two_out0 got %h v%b exp a5a5000000000001 v1", out0, out0_valid); else pass_cnt++;
    chk_cnt++; if (out1 !== 64'h2 || !out1_valid) $display("FAIL two_out1 got %h v%b exp 2 v1", out1, out1_valid); else pass_cnt++;
    chk_cnt++; if (out0_cnt !== 2'd1 || out1_cnt !== 2'd1) $display("FAIL two_cnts got %0d/%0d exp 1/1", out0_cnt, out1_cnt); else pass_cnt++;
    step(); step();
    chk_cnt++; if (out0 !== 64'hA5A5_0000_0000_0001) $display("FAIL two_out0_hold got %h exp a5a5000000000001", out0); else pass_cnt++;
  endtask
  task automatic test_full();
    do_reset();
    s = 0; in_valid = 1; in = 64'h11;
    step();
    in = 64'h22;
    chk_cnt++; if (in_ready !== 1'b1) $display("FAIL full_ready1 got %b exp 1", in_ready); else pass_cnt++;
    step();
    in = 64'h33;
    chk_cnt++; if (in_ready !== 1'b0 || out0_cnt !== 2'd2) $display("FAIL full_ready2 got %b cnt %0d exp 0 cnt 2", in_ready, out0_cnt); else pass_cnt++;
    step();
    chk_cnt++; if (in_ready !== 1'b0 || out0_cnt !== 2'd2 || out0 !== 64'h11) $display("FAIL full_hold got %b cnt %0d out %h exp 0 2 11", in_ready, out0_cnt, out0); else pass_cnt++;
    out0_ready = 1;
    chk_cnt++; if (in_ready !== 1'b0) $display("FAIL full_no_pass got %b exp 0", in_ready); else pass_cnt++;
    step();
    out0_ready = 0;
    chk_cnt++; if (out0_cnt !== 2'd1 || out0 !== 64'h22) $display("FAIL full_pop got cnt %0d out %h exp 1 22", out0_cnt, out0); else pass_cnt++;
    chk_cnt++; if (in_ready !== 1'b1) $display("FAIL full_ready3 got %b exp 1", in_ready); else pass_cnt++;
    step();
    in_valid = 0;
    chk_cnt++; if (out0_cnt !== 2'd2 || out0 !== 64'h22) $display("FAIL full_third got cnt %0d out %h exp 2 22", out0_cnt, out0); else pass_cnt++;
    out0_ready = 1;
    step();
    chk_cnt++; if (out0_cnt !== 2'd1 || out0 !== 64'h33) $display("FAIL full_order got cnt %0d out %h exp 1 33", out0_cnt, out0); else pass_cnt++;
    step();
    out0_ready = 0;
    chk_cnt++; if (out0_valid !== 1'b0 || out0 !== 64'h33) $display("FAIL full_empty_hold got v%b out %h exp v0 33", out0_valid, out0); else pass_cnt++;
  endtask
  task automatic test_stream();
    int got0 = 0, got1 = 0;
    logic [63:0] lane_out;
    do_reset();
    out0_ready = 1; out1_ready = 1; in_valid = 1;
    for (int i = 0; i < 16; i++) begin
      in = 64'(100 + i); s = i[0];
      chk_cnt++; if (in_ready !== 1'b1) $display("FAIL stream_ready[%0d] got %b exp 1", i, in_ready); else pass_cnt++;
      step();
      lane_out = i[0] ? out1 : out0;
      chk_cnt++; if (lane_out !== 64'(100 + i)) $display("FAIL stream_data[%0d] got %0d exp %0d", i, lane_out, 100 + i); else pass_cnt++;
      chk_cnt++; if (out0_cnt > 2'd1 || out1_cnt > 2'd1) $display("FAIL stream_cnt[%0d] got %0d/%0d exp <=1", i, out0_cnt, out1_cnt); else pass_cnt++;
      if (out0_valid) got0++;
      if (out1_valid) got1++;
    end
    in_valid = 0;
    step();
    if (out0_valid) got0++;
    if (out1_valid) got1++;
    step();
    chk_cnt++; if (got0 != 8 || got1 != 8) $display("FAIL stream_total got %0d/%0d exp 8/8", got0, got1); else pass_cnt++;
  endtask
  task automatic test_reset_full();
    do_reset();
    in_valid = 1;
    for (int i = 0; i < 4; i++) begin
`ifdef DEMUX_ALT_SEL_EN
      s = 1;
`else
      s = i[1];
`endif
      in = 64'(i + 1);
      step();
    end
    in_valid = 0;
    chk_cnt++; if (out0_cnt !== 2'd2 || out1_cnt !== 2'd2) $display("FAIL rf_fill got %0d/%0d exp 2/2", out0_cnt, out1_cnt); else pass_cnt++;
    rst = 1;
    step();
    rst = 0;
    chk_cnt++; if ({out0_valid, out1_valid} !== 2'b00 || {out0_cnt, out1_cnt} !== 4'h0) $display("FAIL rf_clear got v%b%b cnt %0d/%0d exp v00 0/0", out0_valid, out1_valid, out0_cnt, out1_cnt); else pass_cnt++;
    chk_cnt++; if (in_ready !== 1'b1) $display("FAIL rf_ready got %b exp 1", in_ready); else pass_cnt++;
`ifdef DEMUX_ALT_SEL_EN
    in_valid = 1; s = 1;
    for (int i = 0; i < 4; i++) begin
      in = 64'(16 + i);
      step();
    end
    in_valid = 0;
    chk_cnt++; if (out0 !== 64'd16 || out1 !== 64'd17 || out0_cnt !== 2'd2 || out1_cnt !== 2'd2) $display("FAIL alt_lanes got %0d/%0d cnt %0d/%0d exp 16/17 2/2", out0, out1, out0_cnt, out1_cnt); else pass_cnt++;
`endif
  endtask
  initial begin
    test_reset();
`ifndef DEMUX_ALT_SEL_EN
    test_two_lanes();
    test_full();
    test_stream();
`endif
    test_reset_full();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
